// File: rtl/jesd_rx_lane_sync.sv
// JESD204B RX per-lane sync front end: CGS state machine, SYNC~ generation,
// resync on consecutive error words, saturating error count and octet alignment.
module jesd_rx_lane_sync #(
  parameter int unsigned OCTETS     = 4,
  parameter int unsigned CGS_MIN_K  = 4,
  parameter int unsigned ERR_THRESH = 3,
  parameter int unsigned ERR_CNT_W  = 16,
  localparam int unsigned AW        = $clog2(OCTETS),
  localparam int unsigned DW        = 8 * OCTETS
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [DW-1:0]        data_i,
  input  logic [OCTETS-1:0]    charisk_i,
  input  logic [OCTETS-1:0]    notintable_i,
  input  logic [OCTETS-1:0]    disperr_i,
  input  logic                 sync_req_i,
  output logic [DW-1:0]        data_o,
  output logic [OCTETS-1:0]    charisk_o,
  output logic                 valid_o,
  output logic                 sync_n_o,
  output logic [1:0]           state_o,
  output logic [AW-1:0]        align_idx_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o
);

  localparam int unsigned RunW    = $clog2(CGS_MIN_K + OCTETS + 1);
  localparam int unsigned ErrRunW = 4;
  localparam int unsigned CntSumW = ((ERR_CNT_W > AW + 1) ? ERR_CNT_W : AW + 1) + 1;

  typedef enum logic [1:0] {
    StInit  = 2'd0,
    StCheck = 2'd1,
    StData  = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [RunW-1:0]        run_q, run_d;
  logic [ErrRunW-1:0]     err_run_q, err_run_d;
  logic [AW-1:0]          align_q, align_d;
  logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic                   valid_q, valid_d;
  logic [DW-1:0]          data_q, data_d;
  logic [OCTETS-1:0]      k_q, k_d;
  logic [DW-1:0]          prev_data_q;
  logic [OCTETS-1:0]      prev_k_q;

  logic [OCTETS-1:0]      bad;
  logic [OCTETS-1:0]      cgs;
  logic                   word_err;
  logic                   all_cgs;
  logic [AW:0]            bad_cnt;
  logic [AW:0]            top_run;
  logic                   top_open;
  logic [AW-1:0]          first_non_cgs;
  logic [RunW-1:0]        run_sum;
  logic [RunW-1:0]        run_sat;
  logic [ErrRunW-1:0]     err_run_inc;
  logic [CntSumW-1:0]     cnt_sum;
  logic [2*DW-1:0]        data_wide;
  logic [2*OCTETS-1:0]    k_wide;

  // Per-octet classification and word-level summaries.
  always_comb begin
    bad           = '0;
    cgs           = '0;
    bad_cnt       = '0;
    top_run       = '0;
    top_open      = 1'b1;
    first_non_cgs = '0;
    for (int i = 0; i < OCTETS; i++) begin
      bad[i]  = notintable_i[i] | disperr_i[i];
      cgs[i]  = charisk_i[i] & ~bad[i] & (data_i[8*i +: 8] == 8'hBC);
      bad_cnt = bad_cnt + (AW + 1)'(bad[i]);
    end
    // Run of K28.5 octets contiguous from the top (latest) lane downward.
    for (int i = OCTETS - 1; i >= 0; i--) begin
      if (top_open && cgs[i]) begin
        top_run = top_run + (AW + 1)'(1);
      end else begin
        top_open = 1'b0;
      end
      if (!cgs[i]) begin
        first_non_cgs = AW'(i);
      end
    end
  end

  assign word_err    = |bad;
  assign all_cgs     = &cgs;
  assign run_sum     = run_q + RunW'(OCTETS);
  assign run_sat     = (run_sum > RunW'(CGS_MIN_K)) ? RunW'(CGS_MIN_K) : run_sum;
  assign err_run_inc = err_run_q + ErrRunW'(1);
  assign cnt_sum     = CntSumW'(err_cnt_q) + CntSumW'(bad_cnt);

  // CGS state machine and error-run tracking.
  always_comb begin
    state_d   = state_q;
    run_d     = run_q;
    err_run_d = err_run_q;
    align_d   = align_q;
    if (sync_req_i) begin
      state_d   = StInit;
      run_d     = '0;
      err_run_d = '0;
    end else begin
      unique case (state_q)
        StInit: begin
          run_d = all_cgs ? run_sat : RunW'(top_run);
          if (run_d >= RunW'(CGS_MIN_K)) begin
            state_d = StCheck;
            run_d   = '0;
          end
        end
        StCheck, StData: begin
          if (word_err) begin
            err_run_d = err_run_inc;
            if (err_run_inc >= ErrRunW'(ERR_THRESH)) begin
              state_d   = StInit;
              err_run_d = '0;
            end
          end else begin
            err_run_d = '0;
            // First clean word that is not pure K28.5 marks the ILAS start.
            if (state_q == StCheck && !all_cgs) begin
              align_d = first_non_cgs;
              state_d = StData;
            end
          end
        end
        default: state_d = StInit;
      endcase
    end
  end

  // Counter, valid flag and aligned data path.
  always_comb begin
    if (sync_req_i) begin
      err_cnt_d = '0;
    end else if (cnt_sum > CntSumW'({ERR_CNT_W{1'b1}})) begin
      err_cnt_d = '1;
    end else begin
      err_cnt_d = ERR_CNT_W'(cnt_sum);
    end
    valid_d   = (state_q == StData) && (state_d == StData);
    data_wide = {data_i, prev_data_q} >> {align_q, 3'b000};
    k_wide    = {charisk_i, prev_k_q} >> align_q;
    data_d    = data_wide[DW-1:0];
    k_d       = k_wide[OCTETS-1:0];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StInit;
      run_q       <= '0;
      err_run_q   <= '0;
      align_q     <= '0;
      err_cnt_q   <= '0;
      valid_q     <= 1'b0;
      data_q      <= '0;
      k_q         <= '0;
      prev_data_q <= '0;
      prev_k_q    <= '0;
    end else begin
      state_q     <= state_d;
      run_q       <= run_d;
      err_run_q   <= err_run_d;
      align_q     <= align_d;
      err_cnt_q   <= err_cnt_d;
      valid_q     <= valid_d;
      data_q      <= data_d;
      k_q         <= k_d;
      prev_data_q <= data_i;
      prev_k_q    <= charisk_i;
    end
  end

  assign data_o      = data_q;
  assign charisk_o   = k_q;
  assign valid_o     = valid_q;
  assign sync_n_o    = (state_q != StInit);
  assign state_o     = state_q;
  assign align_idx_o = align_q;
  assign err_cnt_o   = err_cnt_q;

endmodule
